conv_row_packer: RTL

//  Transmit side of the 128-lane row convolver's data bus. Accepts a serial
//  8-bit pixel stream with valid/ready handshake and assembles one image row
//  of ROW_PIX pixels into the padded (ROW_PIX+2)*PIX_W-bit word the convolver

---
 rtl/conv_row_packer.sv | 115 +++++++++++
 1 files changed

// File: rtl/conv_row_packer.sv
// Serial-pixel to padded-row packer for the row convolver: one assembly buffer
// fills while the previous row is held in the output register.
module conv_row_packer #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 128,
  parameter int PAD_MODE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pixel,
  input  logic                         in_last,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [(ROW_PIX+2)*PIX_W-1:0] row_data,
  output logic                         short_row
);

  localparam int              CW       = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int              RW       = (ROW_PIX + 2) * PIX_W;
  localparam logic [CW-1:0]   LAST_IDX = CW'(ROW_PIX - 1);
  localparam logic [0:0]      S_FILL   = 1'b0;
  localparam logic [0:0]      S_FULL   = 1'b1;

  // Border/tail byte: either a copy of the supplied edge pixel or zero.
  function automatic logic [PIX_W-1:0] pad_byte(input logic [PIX_W-1:0] px);
    return (PAD_MODE != 0) ? px : '0;
  endfunction

  logic [0:0]       state_p0;
  logic [CW-1:0]    cnt_p0;
  logic [PIX_W-1:0] asm_p0 [ROW_PIX];
  logic [CW-1:0]    end_idx_p0;
  logic [PIX_W-1:0] end_px_p0;
  logic             vld_p1;

  logic             accept;
  logic             complete;
  logic             out_free;
  logic             xfer;
  logic [CW-1:0]    e_idx;
  logic [PIX_W-1:0] e_px;
  logic [PIX_W-1:0] pix_sel [ROW_PIX];
  logic [RW-1:0]    row_nxt;

  assign in_ready  = ~reset & (state_p0 == S_FILL);
  assign row_valid = vld_p1;

  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (cnt_p0 == LAST_IDX));
  assign out_free = ~vld_p1 | row_ready;
  assign xfer     = out_free & (complete | (state_p0 == S_FULL));

  // The completing pixel is not in the buffer yet, so it is muxed in directly
  // to give a one-cycle accept-to-row_valid latency.
  assign e_idx = complete ? cnt_p0 : end_idx_p0;
  assign e_px  = complete ? in_pixel : end_px_p0;

  always_comb begin
    for (int j = 0; j < ROW_PIX; j++) begin
      pix_sel[j] = (complete && (cnt_p0 == CW'(j))) ? in_pixel : asm_p0[j];
    end
  end

  always_comb begin
    row_nxt = '0;
    row_nxt[PIX_W-1:0] = pad_byte(pix_sel[0]);
    for (int j = 0; j < ROW_PIX; j++) begin
      row_nxt[(j+1)*PIX_W +: PIX_W] = (CW'(j) <= e_idx) ? pix_sel[j] : pad_byte(e_px);
    end
    row_nxt[(ROW_PIX+1)*PIX_W +: PIX_W] = pad_byte(e_px);
  end

  // ---- stage p0: assembly buffer (data, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      asm_p0[cnt_p0] <= in_pixel;
    end
    if (complete) begin
      end_idx_p0 <= cnt_p0;
      end_px_p0  <= in_pixel;
    end
  end

  // ---- stage p0 control / stage p1 output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0  <= S_FILL;
      cnt_p0    <= '0;
      vld_p1    <= 1'b0;
      row_data  <= '0;
      short_row <= 1'b0;
    end else begin
      if (accept) begin
        cnt_p0 <= complete ? '0 : cnt_p0 + CW'(1);
      end
      if (accept && in_last && (cnt_p0 != LAST_IDX)) begin
        short_row <= 1'b1;
      end
      case (state_p0)
        S_FILL:  if (complete && !out_free) state_p0 <= S_FULL;
        S_FULL:  if (out_free) state_p0 <= S_FILL;
        default: state_p0 <= S_FILL;
      endcase
      if (xfer) begin
        vld_p1   <= 1'b1;
        row_data <= row_nxt;
      end else if (row_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule
